// File: rtl/button_conditioner_if.sv
// -----------------------------------------------------------------------------
// button_conditioner_if
// Bundles the raw front-panel inputs and the conditioned outputs of the
// button conditioner.
//   master : the side that owns the raw buttons/switches and consumes strobes
//   slave  : the conditioner itself
// Signals:
//   key_up_n, key_down_n, key_set_n   raw pushbuttons, active-low, async
//   sw_activate_raw, sw_sel_raw       raw slide switches, active-high, async
//   btn_up_export, btn_down_export    one-cycle strobes with auto-repeat
//   btn_set_export                    one-cycle strobe, no repeat
//   swc_activate_export, swc_sel_export  debounced switch levels
// -----------------------------------------------------------------------------
interface button_conditioner_if;
    logic key_up_n;
    logic key_down_n;
    logic key_set_n;
    logic sw_activate_raw;
    logic sw_sel_raw;
    logic btn_up_export;
    logic btn_down_export;
    logic btn_set_export;
    logic swc_activate_export;
    logic swc_sel_export;

    modport master (
        output key_up_n, key_down_n, key_set_n, sw_activate_raw, sw_sel_raw,
        input  btn_up_export, btn_down_export, btn_set_export,
               swc_activate_export, swc_sel_export
    );

    modport slave (
        input  key_up_n, key_down_n, key_set_n, sw_activate_raw, sw_sel_raw,
        output btn_up_export, btn_down_export, btn_set_export,
               swc_activate_export, swc_sel_export
    );
endinterface

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Synchronizes and debounces three pushbuttons and two slide switches.
// Up/down produce a press strobe followed by auto-repeat while held and are
// mutually locked out when both are held; set produces a single press strobe;
// the switches produce debounced levels.
// Ports:
//   clk_clk        system clock, rising edge
//   reset_reset_n  asynchronous active-low reset
//   bus            button_conditioner_if.slave (raw inputs in, strobes/levels out)
// Latency from a stable raw edge to the output is DEBOUNCE_CYCLES+3 edges:
// 2 synchronizer edges, DEBOUNCE_CYCLES edges to accept, 1 output register.
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    button_conditioner_if.slave  bus
);

    localparam int NUM_CH  = 5;
    localparam int CH_UP   = 0;
    localparam int CH_DOWN = 1;
    localparam int CH_SET  = 2;
    localparam int CH_ACT  = 3;
    localparam int CH_SEL  = 4;

    // Inactive level per channel: keys released (1), switches off (0).
    localparam logic [NUM_CH-1:0] IDLE_LEVEL = 5'b00111;

    localparam logic [24:0] DB_LAST = 25'(DEBOUNCE_CYCLES - 1);
    localparam logic [24:0] RD_LAST = 25'(REPEAT_DELAY - 1);
    localparam logic [24:0] RP_LAST = 25'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} rep_state_t;

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;
    logic [NUM_CH-1:0] acc;     // accepted (debounced) level, raw polarity
    logic [NUM_CH-1:0] acc_d;   // accepted level one edge later, for edge detect
    logic [24:0]       db_cnt [NUM_CH];

    assign raw = {bus.sw_sel_raw, bus.sw_activate_raw,
                  bus.key_set_n, bus.key_down_n, bus.key_up_n};

    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples the pre-edge value of its source; blocking here
    // would collapse the two synchronizer stages into one.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1 <= IDLE_LEVEL;
            sync2 <= IDLE_LEVEL;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: count consecutive cycles the synchronized value disagrees
    // with the accepted level; any agreeing cycle restarts the count.
    // NOTE: the counter array is a handful of flops, not a RAM, so it is
    // reset like any other state; a held key must restart from scratch.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            acc   <= IDLE_LEVEL;
            acc_d <= IDLE_LEVEL;
            for (int i = 0; i < NUM_CH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            acc_d <= acc;
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync2[i] == acc[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    acc[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 25'd1;
                end
            end
        end
    end

    logic [2:0] pressed;
    logic [2:0] pressed_d;
    logic       lock;

    assign pressed   = ~acc[2:0];
    assign pressed_d = ~acc_d[2:0];
    assign lock      = pressed[CH_UP] & pressed[CH_DOWN];

    // Up/down repeat FSMs, index 0 = up, 1 = down.
    rep_state_t  state_q [2];
    rep_state_t  state_n [2];
    logic [24:0] tmr_q   [2];
    logic [24:0] tmr_n   [2];
    logic [1:0]  rep_strobe_q;
    logic [1:0]  rep_strobe_n;
    logic        set_strobe_q;

    // NOTE: every output of this block gets a default before any branch,
    // otherwise a path that skips an assignment infers a latch.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_n[ch]      = state_q[ch];
            tmr_n[ch]        = tmr_q[ch] + 25'd1;
            rep_strobe_n[ch] = 1'b0;
            if (lock) begin
                // Lock has priority, which also suppresses a strobe when both
                // presses are accepted on the same edge.
                state_n[ch] = LOCK;
                tmr_n[ch]   = '0;
            end else begin
                case (state_q[ch])
                    IDLE: begin
                        tmr_n[ch] = '0;
                        if (pressed[ch] && !pressed_d[ch]) begin
                            state_n[ch]      = DELAY;
                            rep_strobe_n[ch] = 1'b1;
                        end
                    end
                    DELAY: begin
                        if (!pressed[ch]) begin
                            state_n[ch] = IDLE;
                            tmr_n[ch]   = '0;
                        end else if (tmr_q[ch] == RD_LAST) begin
                            state_n[ch]      = REPEAT;
                            tmr_n[ch]        = '0;
                            rep_strobe_n[ch] = 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (!pressed[ch]) begin
                            state_n[ch] = IDLE;
                            tmr_n[ch]   = '0;
                        end else if (tmr_q[ch] == RP_LAST) begin
                            tmr_n[ch]        = '0;
                            rep_strobe_n[ch] = 1'b1;
                        end
                    end
                    LOCK: begin
                        // Leave only on this channel's own release, so a key
                        // still held after the other lets go stays silent.
                        tmr_n[ch] = '0;
                        if (!pressed[ch]) begin
                            state_n[ch] = IDLE;
                        end
                    end
                    default: begin
                        state_n[ch] = IDLE;
                        tmr_n[ch]   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= IDLE;
                tmr_q[ch]   <= '0;
            end
            rep_strobe_q <= '0;
            set_strobe_q <= 1'b0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= state_n[ch];
                tmr_q[ch]   <= tmr_n[ch];
            end
            rep_strobe_q <= rep_strobe_n;
            set_strobe_q <= pressed[CH_SET] & ~pressed_d[CH_SET];
        end
    end

    assign bus.btn_up_export       = rep_strobe_q[CH_UP];
    assign bus.btn_down_export     = rep_strobe_q[CH_DOWN];
    assign bus.btn_set_export      = set_strobe_q;
    // acc_d is the accepted level registered once more, which lines the
    // switch outputs up with the strobe latency.
    assign bus.swc_activate_export = acc_d[CH_ACT];
    assign bus.swc_sel_export      = acc_d[CH_SEL];

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Reference model: each accepted level flips once the last DEBOUNCE_CYCLES
// raw samples (seen two edges late through the synchronizer) all disagree
// with it; repeat strobes are scheduled by absolute due cycle.
// Expected outputs are queued per edge and compared by a separate monitor.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 5;
    localparam logic [4:0] IDLE_RAW = 5'b00111;   // sel,act,set,down,up

    logic clk = 1'b0;
    logic reset_reset_n;
    logic [4:0] raw_in;

    button_conditioner_if bus();

    assign bus.key_up_n        = raw_in[0];
    assign bus.key_down_n      = raw_in[1];
    assign bus.key_set_n       = raw_in[2];
    assign bus.sw_activate_raw = raw_in[3];
    assign bus.sw_sel_raw      = raw_in[4];

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk_clk      (clk),
        .reset_reset_n(reset_reset_n),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic up;
        logic down;
        logic set;
        logic act;
        logic sel;
    } outs_t;

    outs_t exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int n_up = 0;
    int n_down = 0;
    int n_set = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic outs_t dut_outs();
        return {bus.btn_up_export, bus.btn_down_export, bus.btn_set_export,
                bus.swc_activate_export, bus.swc_sel_export};
    endfunction

    function automatic logic out_bit(input int which);
        case (which)
            0:       return bus.btn_up_export;
            1:       return bus.btn_down_export;
            2:       return bus.btn_set_export;
            3:       return bus.swc_activate_export;
            default: return bus.swc_sel_export;
        endcase
    endfunction

    // ---------------- reference model ----------------
    logic [4:0] raw_log[$];
    logic [4:0] m_acc;
    logic [4:0] m_prev;
    logic [4:0] m_new;
    bit         m_active [2];
    bit         m_locked [2];
    int         m_due    [2];
    int         cyc;
    outs_t      m_e;
    bit         m_p, m_p2, m_lock, m_s, m_all;

    always @(posedge clk) begin : model
        if (!reset_reset_n) begin
            raw_log.delete();
            for (int k = 0; k < D + 2; k++) raw_log.push_back(IDLE_RAW);
            m_acc  = IDLE_RAW;
            m_prev = IDLE_RAW;
            for (int ch = 0; ch < 2; ch++) begin
                m_active[ch] = 1'b0;
                m_locked[ch] = 1'b0;
                m_due[ch]    = 0;
            end
            cyc = 0;
            exp_q.push_back('0);
        end else begin
            cyc++;
            m_e     = '0;
            m_e.set = !m_acc[2] && m_prev[2];
            m_e.act = m_acc[3];
            m_e.sel = m_acc[4];
            m_lock  = !m_acc[0] && !m_acc[1];
            for (int ch = 0; ch < 2; ch++) begin
                m_p  = !m_acc[ch];
                m_p2 = !m_prev[ch];
                m_s  = 1'b0;
                if (m_lock) begin
                    m_locked[ch] = 1'b1;
                    m_active[ch] = 1'b0;
                end else if (m_locked[ch]) begin
                    if (!m_p) m_locked[ch] = 1'b0;
                end else if (m_active[ch]) begin
                    if (!m_p) begin
                        m_active[ch] = 1'b0;
                    end else if (cyc == m_due[ch]) begin
                        m_s       = 1'b1;
                        m_due[ch] = cyc + RP;
                    end
                end else if (m_p && !m_p2) begin
                    m_s          = 1'b1;
                    m_active[ch] = 1'b1;
                    m_due[ch]    = cyc + RD;
                end
                if (ch == 0) m_e.up = m_s;
                else         m_e.down = m_s;
            end
            // Window of raw samples taken D+1 .. 2 edges ago.
            raw_log.push_back(raw_in);
            void'(raw_log.pop_front());
            m_new = m_acc;
            for (int i = 0; i < 5; i++) begin
                m_all = 1'b1;
                for (int k = 0; k < D; k++) begin
                    if (raw_log[k][i] == m_acc[i]) m_all = 1'b0;
                end
                if (m_all) m_new[i] = ~m_acc[i];
            end
            m_prev = m_acc;
            m_acc  = m_new;
            exp_q.push_back(m_e);
        end
    end

    // ---------------- monitor ----------------
    outs_t prev_got = '0;

    always @(negedge clk) begin : monitor
        outs_t e;
        outs_t got;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            got = dut_outs();
            check("outputs", int'(got), int'(e));
            if (got.up || got.down || got.set) begin
                check("no_back_to_back",
                      int'({got.up & prev_got.up, got.down & prev_got.down,
                            got.set & prev_got.set}), 0);
            end
            n_up   += int'(got.up);
            n_down += int'(got.down);
            n_set  += int'(got.set);
            prev_got = got;
        end
    end

    // ---------------- stimulus ----------------
    // Inputs change 3 time units before a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    // Edges from now until the chosen output is first seen high (-1 on timeout).
    task automatic wait_for(input int which, output int lat);
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (out_bit(which)) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int base;
        int pr;
        reset_reset_n = 1'b0;
        raw_in        = IDLE_RAW;
        tick(3);
        check("reset_state", int'(dut_outs()), 0);
        reset_reset_n = 1'b1;
        tick(10);

        // Set key: one strobe 7 edges after the press, nothing on release.
        base = n_set;
        raw_in[2] = 1'b0;
        wait_for(2, lat);
        check("set_latency", lat, 7);
        tick(43);
        check("set_single_pulse", n_set - base, 1);
        raw_in[2] = 1'b1;
        tick(20);
        check("set_no_release_pulse", n_set - base, 1);

        // Up key: 3-cycle glitch is ignored.
        base = n_up;
        raw_in[0] = 1'b0;
        tick(3);
        raw_in[0] = 1'b1;
        tick(15);
        check("glitch_no_strobe", n_up - base, 0);

        // Up key held 35 samples: strobes at +7, +27, +32, +37 only.
        base = n_up;
        raw_in[0] = 1'b0;
        wait_for(0, lat);
        check("up_latency", lat, 7);
        tick(29);
        raw_in[0] = 1'b1;
        tick(30);
        check("up_repeat_count", n_up - base, 4);

        // Up and down together: locked, then up stays locked after down lets go.
        base = n_up + n_down;
        raw_in[1:0] = 2'b00;
        tick(30);
        check("lock_no_strobe", (n_up + n_down) - base, 0);
        raw_in[1] = 1'b1;
        tick(20);
        check("lock_held_after_other_release", (n_up + n_down) - base, 0);
        raw_in[0] = 1'b1;
        tick(15);
        raw_in[0] = 1'b0;
        wait_for(0, lat);
        check("unlock_repress_latency", lat, 7);
        tick(1);
        raw_in[0] = 1'b1;
        tick(20);

        // Select switch: 2-cycle pulse ignored, held level accepted at +7.
        raw_in[4] = 1'b1;
        tick(2);
        raw_in[4] = 1'b0;
        tick(12);
        check("sel_pulse_ignored", int'(out_bit(4)), 0);
        raw_in[4] = 1'b1;
        wait_for(4, lat);
        check("sel_latency", lat, 7);
        tick(5);
        raw_in[4] = 1'b0;
        tick(12);

        // Down held, reset at +15, then a fresh strobe 7 edges after release.
        raw_in[1] = 1'b0;
        wait_for(1, lat);
        check("down_latency", lat, 7);
        tick(8);
        reset_reset_n = 1'b0;
        tick(1);
        check("reset_mid_repeat_outputs", int'(dut_outs()), 0);
        reset_reset_n = 1'b1;
        wait_for(1, lat);
        check("reset_recovery_latency", lat, 7);
        tick(1);
        raw_in[1] = 1'b1;
        tick(20);

        // Random toggling: short bursts first, then long holds for repeats.
        for (int c = 0; c < 3000; c++) begin
            tick(1);
            pr = (c < 1500) ? 6 : 40;
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(0, pr - 1) == 0) raw_in[i] = ~raw_in[i];
            end
            if ($urandom_range(0, 499) == 0) begin
                reset_reset_n = 1'b0;
                tick(1);
                reset_reset_n = 1'b1;
            end
        end

        raw_in = IDLE_RAW;
        tick(20);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
